// File: rtl/hpdmc_sdram_responder.sv
// hpdmc_sdram_responder: device-side model of the SDRAM command bus.
// Decodes commands, tracks per-bank open rows, checks tRP/tRCD/tRFC/tREFI
// spacing into sticky error bits, and drives a flat word-storage port.
// Optional feature macro: HPDMC_RESP_REFI_CHECK_EN enables the tREFI
// up-counter and err[5]; without it err[5] is tied low.

// One bank: open/row state plus its tRP and tRCD down-counters.
module hpdmc_sdram_bank #(
  parameter int ROW_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             pre,
  input  logic [ROW_W-1:0] row_in,
  input  logic [2:0]       tim_rp,
  input  logic [2:0]       tim_rcd,
  output logic             open,
  output logic [ROW_W-1:0] row,
  output logic [2:0]       rp,
  output logic [2:0]       rcd
);
  // ACT opens and reloads tRCD; PRE closes and reloads tRP; otherwise count down to 0.
  // The row is kept across PRE so accesses to a closed bank use the stale row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open <= 1'b0;
      row  <= '0;
      rp   <= '0;
      rcd  <= '0;
    end else begin
      if (act) begin
        open <= 1'b1;
        row  <= row_in;
        rcd  <= tim_rcd;
      end else if (rcd != 3'd0) begin
        rcd <= rcd - 3'd1;
      end
      if (pre) begin
        open <= 1'b0;
        rp   <= tim_rp;
      end else if (rp != 3'd0) begin
        rp <= rp - 3'd1;
      end
    end
  end
endmodule

module hpdmc_sdram_responder #(
  parameter int sdram_depth       = 26,
  parameter int sdram_columndepth = 10,
  parameter int cas_latency       = 2,
  parameter int refi_slack        = 8
) (
  input  logic                   sys_clk,
  input  logic                   sdram_rst,
  input  logic                   sdram_cs_n,
  input  logic                   sdram_ras_n,
  input  logic                   sdram_cas_n,
  input  logic                   sdram_we_n,
  input  logic [12:0]            sdram_adr,
  input  logic [1:0]             sdram_ba,
  input  logic [2:0]             tim_rp,
  input  logic [2:0]             tim_rcd,
  input  logic [3:0]             tim_rfc,
  input  logic [10:0]            tim_refi,
  input  logic                   err_clr,
  output logic [sdram_depth-2:0] mem_adr,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic                   rd_valid,
  output logic [5:0]             err,
  output logic [15:0]            refresh_count
);
  localparam int ROW_W     = sdram_depth - 3 - sdram_columndepth;
  localparam int NUM_BANKS = 4;

  logic [2:0] rcw;
  logic       is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, non_nop;

  assign rcw     = {sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign is_act  = ~sdram_cs_n & (rcw == 3'b011);
  assign is_rd   = ~sdram_cs_n & (rcw == 3'b101);
  assign is_wr   = ~sdram_cs_n & (rcw == 3'b100);
  assign is_pre  = ~sdram_cs_n & (rcw == 3'b010);
  assign is_ref  = ~sdram_cs_n & (rcw == 3'b001);
  assign is_lmr  = ~sdram_cs_n & (rcw == 3'b000);
  assign non_nop = ~sdram_cs_n & (rcw != 3'b111);

  logic [NUM_BANKS-1:0]            bank_act, bank_pre, bank_open, bank_rp_busy;
  logic [NUM_BANKS-1:0][ROW_W-1:0] bank_row;
  logic [NUM_BANKS-1:0][2:0]       bank_rp, bank_rcd;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign bank_act[g]     = is_act & (sdram_ba == 2'(g));
    assign bank_pre[g]     = is_pre & (sdram_adr[10] | (sdram_ba == 2'(g)));
    assign bank_rp_busy[g] = |bank_rp[g];
    hpdmc_sdram_bank #(.ROW_W(ROW_W)) u_bank (
      .clk    (sys_clk),
      .rst    (sdram_rst),
      .act    (bank_act[g]),
      .pre    (bank_pre[g]),
      .row_in (sdram_adr[ROW_W-1:0]),
      .tim_rp (tim_rp),
      .tim_rcd(tim_rcd),
      .open   (bank_open[g]),
      .row    (bank_row[g]),
      .rp     (bank_rp[g]),
      .rcd    (bank_rcd[g])
    );
  end

  // Global tRFC down-counter, reloaded by REF.
  logic [3:0] rfc;
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst)           rfc <= '0;
    else if (is_ref)         rfc <= tim_rfc;
    else if (rfc != 4'd0)    rfc <= rfc - 4'd1;
  end

  logic refi_viol;
`ifdef HPDMC_RESP_REFI_CHECK_EN
  // Cycles since the last REF; the check looks at the value being loaded so
  // err[5] rises on the same cycle the counter passes the limit.
  logic [11:0] refi, refi_nxt;
  logic [12:0] refi_lim;
  assign refi_nxt  = is_ref ? 12'd0 : ((refi == 12'hFFF) ? refi : refi + 12'd1);
  assign refi_lim  = 13'(tim_refi) + 13'(refi_slack);
  assign refi_viol = {1'b0, refi_nxt} > refi_lim;
  // tREFI up-counter.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) refi <= '0;
    else           refi <= refi_nxt;
  end
`else
  logic unused_refi;
  assign unused_refi = ^tim_refi;
  assign refi_viol   = 1'b0;
`endif

  // Violations raised by this cycle's command.
  logic [5:0] viol;
  always_comb begin
    viol    = '0;
    viol[0] = (is_act & bank_open[sdram_ba]) | (is_lmr & (|bank_open));
    viol[1] = (is_act & bank_rp_busy[sdram_ba]) | (is_ref & (|bank_rp_busy));
    viol[2] = (is_rd | is_wr) & ~bank_open[sdram_ba];
    viol[3] = (is_rd | is_wr) & (|bank_rcd[sdram_ba]);
    viol[4] = (is_ref & (|bank_open)) | (non_nop & (rfc != 4'd0));
    viol[5] = refi_viol;
  end

  // Sticky errors; a violation in the clear cycle still lands.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) err <= '0;
    else           err <= (err_clr ? 6'd0 : err) | viol;
  end

  // Storage port strobes and address, one cycle after the command.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      mem_adr <= '0;
    end else begin
      mem_re <= is_rd;
      mem_we <= is_wr;
      if (is_rd | is_wr)
        mem_adr <= {bank_row[sdram_ba], sdram_ba, sdram_adr[sdram_columndepth-1:0]};
    end
  end

  // CAS-latency shift register: stage k is a READ issued k cycles ago.
  logic [cas_latency:1] vld_pipe;
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= is_rd;
      for (int k = 2; k <= cas_latency; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end
  assign rd_valid = vld_pipe[cas_latency];

  // REF counter, wraps naturally.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst)   refresh_count <= '0;
    else if (is_ref) refresh_count <= refresh_count + 16'd1;
  end
endmodule

// File: tb/tb_hpdmc_sdram_responder.sv
// Bench for hpdmc_sdram_responder: timestamp-based model plus literal checks.
module tb_hpdmc_sdram_responder;
  localparam int CL    = 2;
  localparam int SLACK = 8;
`ifdef HPDMC_RESP_REFI_CHECK_EN
  localparam logic REFI_EN = 1'b1;
`else
  localparam logic REFI_EN = 1'b0;
`endif
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101,
                         C_WR = 3'b100, C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

  logic        clk, rst;
  logic        cs_n, ras_n, cas_n, we_n, err_clr;
  logic [12:0] adr;
  logic [1:0]  ba;
  logic [2:0]  tim_rp, tim_rcd;
  logic [3:0]  tim_rfc;
  logic [10:0] tim_refi;
  logic [24:0] mem_adr;
  logic        mem_re, mem_we, rd_valid;
  logic [5:0]  err;
  logic [15:0] refresh_count;

  hpdmc_sdram_responder #(.sdram_depth(26), .sdram_columndepth(10),
                          .cas_latency(CL), .refi_slack(SLACK)) dut (
    .sys_clk(clk), .sdram_rst(rst),
    .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_adr(adr), .sdram_ba(ba),
    .tim_rp(tim_rp), .tim_rcd(tim_rcd), .tim_rfc(tim_rfc), .tim_refi(tim_refi),
    .err_clr(err_clr),
    .mem_adr(mem_adr), .mem_re(mem_re), .mem_we(mem_we), .rd_valid(rd_valid),
    .err(err), .refresh_count(refresh_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0;

  // Model: n = index of the last clock edge since reset; timestamps of commands.
  int          n, base, last_ref;
  int          last_pre[4], last_act[4];
  bit          m_open[4];
  logic [12:0] m_row[4];
  bit          e_re[0:2047], e_we[0:2047], e_rdv[0:2047];
  logic [24:0] m_adr;
  logic [5:0]  m_err;
  logic [15:0] m_rc;
  bit          run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; base = 0; last_ref = -100;
    for (int i = 0; i < 4; i++) begin
      last_pre[i] = -100; last_act[i] = -100; m_open[i] = 1'b0; m_row[i] = '0;
    end
    for (int i = 0; i < 2048; i++) begin
      e_re[i] = 1'b0; e_we[i] = 1'b0; e_rdv[i] = 1'b0;
    end
    m_adr = '0; m_err = '0; m_rc = '0;
  endtask

  // Outputs compared against the model on every falling edge.
  always @(negedge clk) begin
    if (run) begin
      chk("mem_re", mem_re, e_re[n]);
      chk("mem_we", mem_we, e_we[n]);
      chk("rd_valid", rd_valid, e_rdv[n]);
      chk("mem_adr", mem_adr, m_adr);
      chk("err", err, m_err);
      chk("refresh_count", refresh_count, m_rc);
    end
  end

  // Drive one command for one clock, updating the model; returns just after the falling edge.
  task automatic step(input logic [2:0] c, input logic [12:0] a, input logic [1:0] b,
                      input logic clr);
    logic [5:0] v;
    bit rd, wr, ac, pr, rf, lm, nn, any_open;
    cs_n = (c == C_NOP); {ras_n, cas_n, we_n} = c; adr = a; ba = b; err_clr = clr;
    n++;
    if (n > 2040) begin
      $display("FAIL cycle_budget: got %0d want below 2040", n);
      $fatal(1);
    end
    rd = (c == C_RD); wr = (c == C_WR); ac = (c == C_ACT); pr = (c == C_PRE);
    rf = (c == C_REF); lm = (c == C_LMR); nn = (c != C_NOP);
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    v = '0;
    if ((ac && m_open[b]) || (lm && any_open)) v[0] = 1'b1;
    if (ac && (n - last_pre[b] <= int'(tim_rp))) v[1] = 1'b1;
    if (rf) for (int i = 0; i < 4; i++) if (n - last_pre[i] <= int'(tim_rp)) v[1] = 1'b1;
    if ((rd || wr) && !m_open[b]) v[2] = 1'b1;
    if ((rd || wr) && (n - last_act[b] <= int'(tim_rcd))) v[3] = 1'b1;
    if ((rf && any_open) || (nn && (n - last_ref <= int'(tim_rfc)))) v[4] = 1'b1;
    m_err = (clr ? 6'd0 : m_err) | v;
    if (rf) begin base = n; last_ref = n; m_rc = m_rc + 16'd1; end
    if (REFI_EN && (n - base > int'(tim_refi) + SLACK)) m_err[5] = 1'b1;
    if (ac) begin m_open[b] = 1'b1; m_row[b] = a; last_act[b] = n; end
    if (pr) for (int i = 0; i < 4; i++)
      if (a[10] || (b == 2'(i))) begin m_open[i] = 1'b0; last_pre[i] = n; end
    if (rd || wr) m_adr = {m_row[b], b, a[9:0]};
    e_re[n] = rd; e_we[n] = wr;
    if (rd) e_rdv[n + CL - 1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic nop(); step(C_NOP, 13'd0, 2'd0, 1'b0); endtask
  task automatic nop_clr(); step(C_NOP, 13'd0, 2'd0, 1'b1); endtask

  initial begin
    rst = 1'b0; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    adr = '0; ba = '0; err_clr = 1'b0;
    tim_rp = 3'd3; tim_rcd = 3'd2; tim_rfc = 4'd4; tim_refi = 11'h7FF;
    #2 rst = 1'b1;
    model_reset();
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_err", err, 6'd0);
    chk("reset_re", mem_re, 1'b0);
    rst = 1'b0;

    // ACT b1 row 0x123, READ col 0x3F three cycles later.
    step(C_ACT, 13'h123, 2'd1, 1'b0); nop(); nop();
    step(C_RD, 13'h03F, 2'd1, 1'b0);
    chk("rd_ok_err", err, 6'd0);
    chk("rd_ok_re", mem_re, 1'b1);
    chk("rd_ok_adr", mem_adr, 25'h12343F);
    nop();
    chk("rd_ok_valid", rd_valid, 1'b1);
    nop();

    // WRITE too soon after ACT: err[3], strobe still fires.
    step(C_ACT, 13'h005, 2'd0, 1'b0); nop();
    step(C_WR, 13'h007, 2'd0, 1'b0);
    chk("wr_rcd_err", err, 6'h08);
    chk("wr_rcd_we", mem_we, 1'b1);
    nop_clr();
    chk("clr_err", err, 6'd0);

    // PRE-all then ACT at +3 (too early) and +4 (legal).
    step(C_PRE, 13'h400, 2'd0, 1'b0); nop(); nop();
    step(C_ACT, 13'h044, 2'd2, 1'b0);
    chk("act_rp_err", err, 6'h02);
    nop_clr();
    step(C_PRE, 13'h400, 2'd0, 1'b0); nop(); nop(); nop();
    step(C_ACT, 13'h044, 2'd2, 1'b0);
    chk("act_rp_ok", err, 6'd0);

    // REF with banks open; then tRFC spacing.
    step(C_ACT, 13'h009, 2'd3, 1'b0); nop(); nop(); nop();
    step(C_REF, 13'd0, 2'd0, 1'b0);
    chk("ref_open_err", err, 6'h10);
    chk("ref_count1", refresh_count, 16'd1);
    nop_clr(); nop(); nop(); nop();
    step(C_PRE, 13'h400, 2'd0, 1'b0);
    chk("pre_after_rfc", err, 6'd0);
    nop(); nop(); nop();
    step(C_REF, 13'd0, 2'd0, 1'b0);
    chk("ref_clean", err, 6'd0);
    chk("ref_count2", refresh_count, 16'd2);
    nop();
    step(C_ACT, 13'h010, 2'd0, 1'b0);
    chk("act_in_rfc", err, 6'h10);
    nop_clr(); nop(); nop();

    // LMR with open bank, ACT to open bank, READ to closed bank (stale row).
    step(C_LMR, 13'h000, 2'd0, 1'b0);
    chk("lmr_open", err, 6'h01);
    nop_clr();
    step(C_ACT, 13'h011, 2'd0, 1'b0);
    chk("act_open", err, 6'h01);
    nop_clr();
    step(C_PRE, 13'h000, 2'd1, 1'b0); nop(); nop(); nop();
    step(C_RD, 13'h002, 2'd1, 1'b0);
    chk("rd_closed_err", err, 6'h04);
    chk("rd_closed_adr", mem_adr, 25'h123402);
    nop_clr(); nop(); nop();

    // Back-to-back READs give back-to-back rd_valid.
    step(C_RD, 13'h001, 2'd0, 1'b0);
    step(C_RD, 13'h002, 2'd0, 1'b0);
    chk("b2b_valid1", rd_valid, 1'b1);
    step(C_RD, 13'h003, 2'd0, 1'b0);
    chk("b2b_valid2", rd_valid, 1'b1);
    nop(); nop();
    step(C_WR, 13'h004, 2'd0, 1'b0); nop();

    // tREFI window: err[5] at refi = tim_refi + slack + 1.
    tim_refi = 11'd100;
    step(C_REF, 13'd0, 2'd0, 1'b0);
    for (int k = 1; k <= 115; k++) begin
      step(C_NOP, 13'd0, 2'd0, k == 1);
      if (k == 108) chk("refi_108", err[5], 1'b0);
      if (k == 109) chk("refi_109", err[5], REFI_EN);
    end

    // Reset in the middle of a read.
    step(C_RD, 13'h005, 2'd0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_re", mem_re, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_err", err, 6'd0);
    chk("rst_count", refresh_count, 16'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) nop();
    chk("post_rst_valid", rd_valid, 1'b0);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
